// File: rtl/mem_ctrl_if.sv
// Internal requester ports and external byte bus of the memory controller.
// master is the controller's view, slave is the environment's view.
interface mem_ctrl_if;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_abort;
   logic        if_done;
   logic [31:0] if_data;

   logic        ls_req;
   logic        ls_wr;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;

   modport master (
      input  mem_din, io_buffer_full,
      input  if_req, if_addr, if_abort,
      input  ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
      output mem_dout, mem_a, mem_wr,
      output if_done, if_data, ls_done, ls_rdata
   );

   modport slave (
      output mem_din, io_buffer_full,
      output if_req, if_addr, if_abort,
      output ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
      input  mem_dout, mem_a, mem_wr,
      input  if_done, if_data, ls_done, ls_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits fetch and load/store requests into
// single-byte bus cycles, honouring the rdy_in pause and I/O back-pressure.
module mem_ctrl #(
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   mem_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_base, w_base_nxt;
   logic [2:0]  r_n, w_n_nxt;
   logic        r_is_if, w_is_if_nxt;
   logic        r_is_io, w_is_io_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic [2:0]  r_aidx, w_aidx_nxt;
   logic [2:0]  r_cidx, w_cidx_nxt;
   logic        r_cap_vld, w_cap_vld_nxt;
   logic [31:0] r_lane, w_lane_nxt;
   logic        r_rdy_q;
   logic        r_if_done, w_if_done_nxt;
   logic        r_ls_done, w_ls_done_nxt;
   logic [31:0] r_if_data, w_if_data_nxt;
   logic [31:0] r_ls_rdata, w_ls_rdata_nxt;

   logic        w_resume;
   logic [2:0]  w_aidx_eff;
   logic        w_issue;
   logic        w_ls_io;
   logic        w_ls_ok;
   logic        w_if_ok;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] wr_byte(input logic [31:0] data, input logic [1:0] idx);
      case (idx)
         2'd0:    return data[7:0];
         2'd1:    return data[15:8];
         2'd2:    return data[23:16];
         default: return data[31:24];
      endcase
   endfunction

   // mem_din is untrusted after a pause, so the first ready cycle re-issues
   // the oldest uncaptured byte instead of the next one.
   assign w_resume   = (r_state == READ) && !r_rdy_q;
   assign w_aidx_eff = w_resume ? r_cidx : r_aidx;
   assign w_issue    = (r_state == READ) && (w_aidx_eff < r_n);
   assign w_ls_io    = (bus.ls_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
   assign w_ls_ok    = bus.ls_req && !r_ls_done;
   assign w_if_ok    = bus.if_req && !r_if_done;

   always_comb begin
      bus.mem_a    = 32'd0;
      bus.mem_wr   = 1'b0;
      bus.mem_dout = 8'd0;
      if (w_issue) begin
         bus.mem_a = r_base + {29'd0, w_aidx_eff};
      end else if (r_state == WRITE) begin
         bus.mem_a    = r_base + {29'd0, r_aidx};
         bus.mem_wr   = 1'b1;
         bus.mem_dout = wr_byte(r_wdata, r_aidx[1:0]);
      end
   end

   assign bus.if_done  = r_if_done;
   assign bus.if_data  = r_if_data;
   assign bus.ls_done  = r_ls_done;
   assign bus.ls_rdata = r_ls_rdata;

   always_comb begin
      w_state_nxt    = r_state;
      w_base_nxt     = r_base;
      w_n_nxt        = r_n;
      w_is_if_nxt    = r_is_if;
      w_is_io_nxt    = r_is_io;
      w_wdata_nxt    = r_wdata;
      w_aidx_nxt     = r_aidx;
      w_cidx_nxt     = r_cidx;
      w_cap_vld_nxt  = r_cap_vld;
      w_lane_nxt     = r_lane;
      w_if_done_nxt  = r_if_done;
      w_ls_done_nxt  = r_ls_done;
      w_if_data_nxt  = r_if_data;
      w_ls_rdata_nxt = r_ls_rdata;

      // With rdy_in low nothing moves, so a pending done pulse is simply held.
      if (rdy_in) begin
         w_if_done_nxt = 1'b0;
         w_ls_done_nxt = 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ls_ok) begin
                  w_base_nxt    = bus.ls_addr;
                  w_n_nxt       = size_bytes(bus.ls_size);
                  w_is_if_nxt   = 1'b0;
                  w_is_io_nxt   = w_ls_io;
                  w_wdata_nxt   = bus.ls_wdata;
                  w_aidx_nxt    = 3'd0;
                  w_cidx_nxt    = 3'd0;
                  w_cap_vld_nxt = 1'b0;
                  w_lane_nxt    = 32'd0;
                  if (!bus.ls_wr)
                     w_state_nxt = READ;
                  else if (w_ls_io && bus.io_buffer_full)
                     w_state_nxt = IO_WAIT;
                  else
                     w_state_nxt = WRITE;
               end else if (w_if_ok) begin
                  w_base_nxt    = bus.if_addr;
                  w_n_nxt       = 3'd4;
                  w_is_if_nxt   = 1'b1;
                  w_is_io_nxt   = 1'b0;
                  w_aidx_nxt    = 3'd0;
                  w_cidx_nxt    = 3'd0;
                  w_cap_vld_nxt = 1'b0;
                  w_lane_nxt    = 32'd0;
                  w_state_nxt   = READ;
               end
            end

            READ: begin
               if (r_is_if && bus.if_abort) begin
                  w_state_nxt   = IDLE;
                  w_cap_vld_nxt = 1'b0;
               end else begin
                  if (w_issue)
                     w_aidx_nxt = w_aidx_eff + 3'd1;
                  w_cap_vld_nxt = w_issue;
                  if (r_cap_vld && !w_resume) begin
                     w_lane_nxt[{r_cidx[1:0], 3'b000} +: 8] = bus.mem_din;
                     w_cidx_nxt = r_cidx + 3'd1;
                     if (w_cidx_nxt == r_n) begin
                        w_state_nxt   = IDLE;
                        w_cap_vld_nxt = 1'b0;
                        if (r_is_if) begin
                           w_if_done_nxt = 1'b1;
                           w_if_data_nxt = w_lane_nxt;
                        end else begin
                           w_ls_done_nxt  = 1'b1;
                           w_ls_rdata_nxt = w_lane_nxt;
                        end
                     end
                  end
               end
            end

            WRITE: begin
               if (r_aidx == r_n - 3'd1) begin
                  w_state_nxt   = IDLE;
                  w_aidx_nxt    = 3'd0;
                  w_ls_done_nxt = 1'b1;
               end else begin
                  w_aidx_nxt = r_aidx + 3'd1;
                  if (r_is_io && bus.io_buffer_full)
                     w_state_nxt = IO_WAIT;
               end
            end

            IO_WAIT: begin
               if (!bus.io_buffer_full)
                  w_state_nxt = WRITE;
            end

            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_base     <= 32'd0;
         r_n        <= 3'd0;
         r_is_if    <= 1'b0;
         r_is_io    <= 1'b0;
         r_wdata    <= 32'd0;
         r_aidx     <= 3'd0;
         r_cidx     <= 3'd0;
         r_cap_vld  <= 1'b0;
         r_lane     <= 32'd0;
         r_rdy_q    <= 1'b1;
         r_if_done  <= 1'b0;
         r_ls_done  <= 1'b0;
         r_if_data  <= 32'd0;
         r_ls_rdata <= 32'd0;
      end else begin
         r_base     <= w_base_nxt;
         r_n        <= w_n_nxt;
         r_is_if    <= w_is_if_nxt;
         r_is_io    <= w_is_io_nxt;
         r_wdata    <= w_wdata_nxt;
         r_aidx     <= w_aidx_nxt;
         r_cidx     <= w_cidx_nxt;
         r_cap_vld  <= w_cap_vld_nxt;
         r_lane     <= w_lane_nxt;
         r_rdy_q    <= rdy_in;
         r_if_done  <= w_if_done_nxt;
         r_ls_done  <= w_ls_done_nxt;
         r_if_data  <= w_if_data_nxt;
         r_ls_rdata <= w_ls_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model with a one-cycle read latency
// sits on the bus, and each scenario is logged per cycle and checked afterwards.
module tb_mem_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rdy   = 1'b1;

   mem_ctrl_if bus ();

   mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rdy_in (rdy),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  ram      [0:4095];
   logic [31:0] wr_log_a [0:63];
   logic [7:0]  wr_log_d [0:63];
   int          wr_cnt = 0;

   // While paused another master owns the bus, so mem_din carries junk.
   always @(posedge clk) begin
      bus.mem_din <= rdy ? ram[bus.mem_a[11:0]] : 8'hEE;
      if (rdy && bus.mem_wr && wr_cnt < 64) begin
         wr_log_a[wr_cnt[5:0]] <= bus.mem_a;
         wr_log_d[wr_cnt[5:0]] <= bus.mem_dout;
         wr_cnt <= wr_cnt + 1;
      end
   end

   bit [31:0] lg_a     [0:63];
   bit [31:0] lg_wr    [0:63];
   bit [31:0] lg_do    [0:63];
   bit [31:0] lg_ifd   [0:63];
   bit [31:0] lg_lsd   [0:63];
   bit [31:0] lg_ifdat [0:63];
   bit [31:0] lg_lsdat [0:63];
   bit        rdy_pat   [0:63];
   bit        full_pat  [0:63];
   bit        abort_pat [0:63];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic clr_pat();
      for (int i = 0; i < 64; i++) begin
         rdy_pat[i[5:0]]   = 1'b1;
         full_pat[i[5:0]]  = 1'b0;
         abort_pat[i[5:0]] = 1'b0;
      end
   endtask

   // Called at posedge+1; runs cycles c0..c1-1 and returns at posedge+1 of c1.
   task automatic run(input int c0, input int c1);
      for (int c = c0; c < c1; c++) begin
         rdy                = rdy_pat[c[5:0]];
         bus.io_buffer_full = full_pat[c[5:0]];
         bus.if_abort       = abort_pat[c[5:0]];
         @(negedge clk);
         lg_a[c[5:0]]     = bus.mem_a;
         lg_wr[c[5:0]]    = 32'(bus.mem_wr);
         lg_do[c[5:0]]    = 32'(bus.mem_dout);
         lg_ifd[c[5:0]]   = 32'(bus.if_done);
         lg_lsd[c[5:0]]   = 32'(bus.ls_done);
         lg_ifdat[c[5:0]] = bus.if_data;
         lg_lsdat[c[5:0]] = bus.ls_rdata;
         @(posedge clk);
         #1;
         if (lg_ifd[c[5:0]] != 0) bus.if_req = 1'b0;
         if (lg_lsd[c[5:0]] != 0) bus.ls_req = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int base;
      for (int i = 0; i < 4096; i++) ram[i[11:0]] = 8'h00;
      ram[12'h000] = 8'h11; ram[12'h001] = 8'h22; ram[12'h002] = 8'h33; ram[12'h003] = 8'h44;
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
      ram[12'h200] = 8'h34; ram[12'h201] = 8'h12;
      bus.io_buffer_full = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_abort = 1'b0;
      bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'b00;
      bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
      clr_pat();

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_a", bus.mem_a, 32'h0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
      chk("rst_if_done", 32'(bus.if_done), 32'h0);
      chk("rst_ls_done", 32'(bus.ls_done), 32'h0);
      chk("rst_if_data", bus.if_data, 32'h0);
      chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // word fetch
      clr_pat();
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      run(0, 8);
      chk("fetch_a1", lg_a[1], 32'h100);
      chk("fetch_a2", lg_a[2], 32'h101);
      chk("fetch_a3", lg_a[3], 32'h102);
      chk("fetch_a4", lg_a[4], 32'h103);
      chk("fetch_done5", lg_ifd[5], 32'h0);
      chk("fetch_done6", lg_ifd[6], 32'h1);
      chk("fetch_data", lg_ifdat[6], 32'h00A00513);
      chk("fetch_done7", lg_ifd[7], 32'h0);
      chk("fetch_idle_a", lg_a[7], 32'h0);
      idle(2);

      // simultaneous load and fetch: load first, fetch in the load's done cycle
      clr_pat();
      bus.ls_addr = 32'h200; bus.ls_size = 2'b01; bus.ls_wr = 1'b0; bus.ls_req = 1'b1;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      run(0, 12);
      chk("simul_a1", lg_a[1], 32'h200);
      chk("simul_a2", lg_a[2], 32'h201);
      chk("simul_lsdone", lg_lsd[4], 32'h1);
      chk("simul_lsdata", lg_lsdat[4], 32'h00001234);
      chk("simul_ifd4", lg_ifd[4], 32'h0);
      chk("simul_lsd5", lg_lsd[5], 32'h0);
      chk("simul_fa5", lg_a[5], 32'h100);
      chk("simul_ifd9", lg_ifd[9], 32'h0);
      chk("simul_ifd10", lg_ifd[10], 32'h1);
      chk("simul_ifdata", lg_ifdat[10], 32'h00A00513);
      idle(2);

      // I/O store under back-pressure
      clr_pat();
      base = wr_cnt;
      for (int c = 0; c < 5; c++) full_pat[c[5:0]] = 1'b1;
      bus.ls_addr = 32'h30000; bus.ls_size = 2'b00; bus.ls_wr = 1'b1;
      bus.ls_wdata = 32'hFFFFFF41; bus.ls_req = 1'b1;
      run(0, 10);
      n = 0;
      for (int c = 0; c < 10; c++) n += int'(lg_wr[c[5:0]]);
      chk("io_nwr", 32'(n), 32'd1);
      chk("io_wr5", lg_wr[5], 32'h0);
      chk("io_wr6", lg_wr[6], 32'h1);
      chk("io_a6", lg_a[6], 32'h30000);
      chk("io_do6", lg_do[6], 32'h41);
      chk("io_lsd6", lg_lsd[6], 32'h0);
      chk("io_lsd7", lg_lsd[7], 32'h1);
      chk("io_logcnt", 32'(wr_cnt - base), 32'd1);
      chk("io_logd", 32'(wr_log_d[base[5:0]]), 32'h41);
      idle(2);

      // pause mid-read
      clr_pat();
      for (int c = 3; c < 6; c++) rdy_pat[c[5:0]] = 1'b0;
      bus.ls_addr = 32'h0; bus.ls_size = 2'b10; bus.ls_wr = 1'b0; bus.ls_req = 1'b1;
      run(0, 12);
      chk("pause_a2", lg_a[2], 32'h1);
      chk("pause_a6", lg_a[6], 32'h1);
      chk("pause_a7", lg_a[7], 32'h2);
      chk("pause_a8", lg_a[8], 32'h3);
      chk("pause_lsd6", lg_lsd[6], 32'h0);
      chk("pause_lsd9", lg_lsd[9], 32'h0);
      chk("pause_lsd10", lg_lsd[10], 32'h1);
      chk("pause_data", lg_lsdat[10], 32'h44332211);
      idle(2);

      // fetch aborted in cycle 3, load accepted in cycle 4
      clr_pat();
      abort_pat[3] = 1'b1;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      run(0, 4);
      bus.if_req = 1'b0;
      bus.ls_addr = 32'h102; bus.ls_size = 2'b00; bus.ls_wr = 1'b0; bus.ls_req = 1'b1;
      run(4, 10);
      n = 0;
      for (int c = 0; c < 10; c++) n += int'(lg_ifd[c[5:0]]);
      chk("abort_nifd", 32'(n), 32'd0);
      chk("abort_a4", lg_a[4], 32'h0);
      chk("abort_a5", lg_a[5], 32'h102);
      chk("abort_lsd7", lg_lsd[7], 32'h1);
      chk("abort_data", lg_lsdat[7], 32'h000000A0);
      idle(2);

      // 2-byte store to RAM
      clr_pat();
      base = wr_cnt;
      bus.ls_addr = 32'h400; bus.ls_size = 2'b01; bus.ls_wr = 1'b1;
      bus.ls_wdata = 32'h1234BEEF; bus.ls_req = 1'b1;
      run(0, 5);
      chk("st_a1", lg_a[1], 32'h400);
      chk("st_do1", lg_do[1], 32'hEF);
      chk("st_a2", lg_a[2], 32'h401);
      chk("st_do2", lg_do[2], 32'hBE);
      chk("st_wr3", lg_wr[3], 32'h0);
      chk("st_lsd3", lg_lsd[3], 32'h1);
      chk("st_logcnt", 32'(wr_cnt - base), 32'd2);
      idle(2);

      // size 11 behaves as a 4-byte load
      clr_pat();
      bus.ls_addr = 32'h100; bus.ls_size = 2'b11; bus.ls_wr = 1'b0; bus.ls_req = 1'b1;
      run(0, 8);
      chk("sz3_lsd5", lg_lsd[5], 32'h0);
      chk("sz3_lsd6", lg_lsd[6], 32'h1);
      chk("sz3_data", lg_lsdat[6], 32'h00A00513);
      idle(2);

      // reset during byte 2 of a 4-byte store
      clr_pat();
      base = wr_cnt;
      bus.ls_addr = 32'h300; bus.ls_size = 2'b10; bus.ls_wr = 1'b1;
      bus.ls_wdata = 32'hDDCCBBAA; bus.ls_req = 1'b1;
      run(0, 3);
      chk("rstst_a3", bus.mem_a, 32'h302);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstst_a", bus.mem_a, 32'h0);
      chk("rstst_wr", 32'(bus.mem_wr), 32'h0);
      chk("rstst_do", 32'(bus.mem_dout), 32'h0);
      chk("rstst_lsd", 32'(bus.ls_done), 32'h0);
      bus.ls_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(0, 6);
      n = 0;
      for (int c = 0; c < 6; c++) n += int'(lg_lsd[c[5:0]]) + int'(lg_wr[c[5:0]]);
      chk("rstst_quiet", 32'(n), 32'd0);
      chk("rstst_logcnt", 32'(wr_cnt - base), 32'd2);
      chk("rstst_b0", 32'(wr_log_d[base[5:0]]), 32'hAA);
      chk("rstst_b1a", wr_log_a[5'(base + 1)], 32'h301);
      chk("rstst_b1", 32'(wr_log_d[5'(base + 1)]), 32'hBB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
